ssd_scan_controller: RTL and testbench

SSD_SCAN_CONTROLLER -- requirements
Module: ssd_scan_controller

---
 rtl/ssd_scan_if.sv | 12 +
 rtl/ssd_scan_controller.sv | 74 +++++++
 tb/tb_ssd_scan_controller.sv | 117 +++++++++++
 3 files changed

// File: rtl/ssd_scan_if.sv
// ssd_scan_if: UART byte input and digit-scan output bundle of the display controller.
interface ssd_scan_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       clear;
    logic [3:0] digit_code;
    logic       dash;
    logic [3:0] dig_sel;
    logic       frame_tick;
    modport master (output rx_data, rx_valid, clear, input digit_code, dash, dig_sel, frame_tick);
    modport slave  (input rx_data, rx_valid, clear, output digit_code, dash, dig_sel, frame_tick);
endinterface

// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller: scans the last two received bytes across four digits,
// blanking every digit at the start of each dwell to suppress ghosting.
module ssd_scan_controller #(
    parameter int MAX_COUNT_SEL = 416_667,
    parameter int BLANK_CYCLES  = 1000
) (
    input logic       clk,
    input logic       rst,
    ssd_scan_if.slave bus
);
    localparam int CW = (MAX_COUNT_SEL > 1) ? $clog2(MAX_COUNT_SEL) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_COUNT_SEL - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    typedef enum logic {BLANK, DRIVE} state_t;
    localparam state_t START = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] new_q, new_d, old_q, old_d;
    logic new_v_q, new_v_d, old_v_q, old_v_d;
    logic [3:0] dig_sel_q, dig_sel_d, code_q, code_d;
    logic dash_q, dash_d, ft_q, ft_d;
    logic wrap, drive, byte_v;
    logic [7:0] byte_sel;
    always_comb begin
        wrap     = cnt_q == CNT_LAST;
        cnt_d    = wrap ? '0 : cnt_q + CW'(1);
        idx_d    = wrap ? idx_q + 2'd1 : idx_q;
        state_d  = (BLANK_CYCLES != 0 && cnt_d < BLANK_END) ? BLANK : DRIVE;
        // clear has priority: a byte arriving with clear is dropped
        new_d    = bus.clear ? 8'h00 : bus.rx_valid ? bus.rx_data : new_q;
        new_v_d  = bus.clear ? 1'b0 : bus.rx_valid ? 1'b1 : new_v_q;
        old_d    = bus.clear ? 8'h00 : bus.rx_valid ? new_q : old_q;
        old_v_d  = bus.clear ? 1'b0 : bus.rx_valid ? new_v_q : old_v_q;
        byte_sel = idx_q[1] ? old_q : new_q;
        byte_v   = idx_q[1] ? old_v_q : new_v_q;
        drive    = state_q == DRIVE;
        dig_sel_d = drive ? 4'b0001 << idx_q : 4'b0000;
        dash_d   = drive && !byte_v;
        code_d   = (drive && byte_v) ? (idx_q[0] ? byte_sel[7:4] : byte_sel[3:0]) : 4'h0;
        ft_d     = wrap && idx_q == 2'd3;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= START;
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            new_q     <= 8'h00;
            old_q     <= 8'h00;
            new_v_q   <= 1'b0;
            old_v_q   <= 1'b0;
            dig_sel_q <= 4'b0000;
            code_q    <= 4'h0;
            dash_q    <= 1'b0;
            ft_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            new_q     <= new_d;
            old_q     <= old_d;
            new_v_q   <= new_v_d;
            old_v_q   <= old_v_d;
            dig_sel_q <= dig_sel_d;
            code_q    <= code_d;
            dash_q    <= dash_d;
            ft_q      <= ft_d;
        end
    end
    assign bus.dig_sel    = dig_sel_q;
    assign bus.digit_code = code_q;
    assign bus.dash       = dash_q;
    assign bus.frame_tick = ft_q;
endmodule

// File: tb/tb_ssd_scan_controller.sv
// tb_ssd_scan_controller: directed vector table for a 4-cycle dwell with 1 blank cycle,
// plus an asynchronous mid-dwell reset sequence.
module tb_ssd_scan_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    ssd_scan_if bus ();
    ssd_scan_controller #(.MAX_COUNT_SEL(4), .BLANK_CYCLES(1)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic       rxv;
        logic [7:0] rxd;
        logic       clr;
        logic [3:0] sel;
        logic       dash;
        logic [3:0] code;
        logic       ft;
    } vec_t;
    vec_t vecs[$];
    int checks = 0;
    int errors = 0;
    task automatic add(input int n, input logic rxv, input logic [7:0] rxd, input logic clr,
                       input logic [3:0] sel, input logic dash, input logic [3:0] code, input logic ft);
        vec_t v;
        v = '{rxv, rxd, clr, sel, dash, code, ft};
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask
    task automatic idle(input int n, input logic [3:0] sel, input logic dash, input logic [3:0] code, input logic ft);
        add(n, 1'b0, 8'h00, 1'b0, sel, dash, code, ft);
    endtask
    task automatic check(input string name, input logic [3:0] sel, input logic dash, input logic [3:0] code, input logic ft);
        checks++;
        if ({bus.dig_sel, bus.dash, bus.digit_code, bus.frame_tick} !== {sel, dash, code, ft}) begin
            errors++;
            $display("FAIL %s: got sel=%b dash=%b code=%h ft=%b, want sel=%b dash=%b code=%h ft=%b",
                     name, bus.dig_sel, bus.dash, bus.digit_code, bus.frame_tick, sel, dash, code, ft);
        end
    endtask
    initial begin
        // row n drives inputs before clock edge n after reset release, checks outputs after it
        idle(1, 4'b0000, 0, 4'h0, 0);
        idle(3, 4'b0001, 1, 4'h0, 0);
        idle(1, 4'b0000, 0, 4'h0, 0);
        idle(3, 4'b0010, 1, 4'h0, 0);
        idle(1, 4'b0000, 0, 4'h0, 0);
        idle(3, 4'b0100, 1, 4'h0, 0);
        idle(1, 4'b0000, 0, 4'h0, 0);
        idle(2, 4'b1000, 1, 4'h0, 0);
        idle(1, 4'b1000, 1, 4'h0, 1);
        add(1, 1'b1, 8'hA5, 1'b0, 4'b0000, 0, 4'h0, 0);
        idle(3, 4'b0001, 0, 4'h5, 0);
        idle(1, 4'b0000, 0, 4'h0, 0);
        idle(3, 4'b0010, 0, 4'hA, 0);
        idle(1, 4'b0000, 0, 4'h0, 0);
        idle(3, 4'b0100, 1, 4'h0, 0);
        idle(1, 4'b0000, 0, 4'h0, 0);
        idle(2, 4'b1000, 1, 4'h0, 0);
        idle(1, 4'b1000, 1, 4'h0, 1);
        add(1, 1'b1, 8'h3C, 1'b0, 4'b0000, 0, 4'h0, 0);
        idle(3, 4'b0001, 0, 4'hC, 0);
        idle(1, 4'b0000, 0, 4'h0, 0);
        idle(3, 4'b0010, 0, 4'h3, 0);
        idle(1, 4'b0000, 0, 4'h0, 0);
        idle(3, 4'b0100, 0, 4'h5, 0);
        idle(1, 4'b0000, 0, 4'h0, 0);
        idle(2, 4'b1000, 0, 4'hA, 0);
        idle(1, 4'b1000, 0, 4'hA, 1);
        add(1, 1'b1, 8'h77, 1'b1, 4'b0000, 0, 4'h0, 0);
        idle(3, 4'b0001, 1, 4'h0, 0);
        idle(1, 4'b0000, 0, 4'h0, 0);
        idle(3, 4'b0010, 1, 4'h0, 0);
        idle(1, 4'b0000, 0, 4'h0, 0);
        idle(3, 4'b0100, 1, 4'h0, 0);
        idle(1, 4'b0000, 0, 4'h0, 0);
        idle(2, 4'b1000, 1, 4'h0, 0);
        add(1, 1'b1, 8'h5E, 1'b0, 4'b1000, 1, 4'h0, 1);
        idle(1, 4'b0000, 0, 4'h0, 0);
        idle(3, 4'b0001, 0, 4'hE, 0);
        idle(1, 4'b0000, 0, 4'h0, 0);
        idle(3, 4'b0010, 0, 4'h5, 0);
        idle(1, 4'b0000, 0, 4'h0, 0);
        idle(2, 4'b0100, 1, 4'h0, 0);
        rst = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        bus.clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 4'b0000, 0, 4'h0, 0);
        rst = 1'b1;
        foreach (vecs[i]) begin
            bus.rx_valid = vecs[i].rxv;
            bus.rx_data  = vecs[i].rxd;
            bus.clear    = vecs[i].clr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i + 1), vecs[i].sel, vecs[i].dash, vecs[i].code, vecs[i].ft);
        end
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        bus.clear = 1'b0;
        rst = 1'b0;
        #2;
        check("rst_async", 4'b0000, 0, 4'h0, 0);
        @(posedge clk);
        #1;
        check("rst_hold", 4'b0000, 0, 4'h0, 0);
        rst = 1'b1;
        @(posedge clk); #1; check("post_rst1", 4'b0000, 0, 4'h0, 0);
        @(posedge clk); #1; check("post_rst2", 4'b0001, 1, 4'h0, 0);
        @(posedge clk); #1; check("post_rst3", 4'b0001, 1, 4'h0, 0);
        @(posedge clk); #1; check("post_rst4", 4'b0001, 1, 4'h0, 0);
        @(posedge clk); #1; check("post_rst5", 4'b0000, 0, 4'h0, 0);
        @(posedge clk); #1; check("post_rst6", 4'b0010, 1, 4'h0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
